// File: rtl/apb_slave_mem_pkg.sv
// Shared definitions for the APB completer memory: FSM encoding, response
// codes, wait-counter width and the address range helper.
package apb_slave_mem_pkg;

  // Wide enough for WAIT_STATES in 0..15.
  localparam int unsigned CNT_W = 4;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when a (zero-extended) word index falls inside the implemented array.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W storage with a synchronous byte-enabled write port and a
// registered read port whose output is cleared when no read is requested.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata/be   write port, commits on the clock edge
//   re/raddr       read request; rdata holds mem[raddr] for the next cycle
//   rdata          registered read data, 0 after any edge with re=0
module apb_slave_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] wr_word_c;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Merge enabled byte lanes into the current word.
  always_comb begin
    wr_word_c = mem_q[waddr];
    for (int b = 0; b < STRB_W; b++) begin
      if (be[b]) wr_word_c[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // Read data; a same-edge write to the same entry is forwarded.
  always_comb begin
    rdata_d = '0;
    if (re) begin
      rdata_d = mem_q[raddr];
      if (we && (waddr == raddr)) rdata_d = wr_word_c;
    end
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wr_word_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word array indexed directly by PADDR. Inserts
// WAIT_STATES PREADY-low access cycles and answers PADDR >= DEPTH with
// PSLVERR (writes dropped, reads return 0).
// Build option: define APB_SLAVE_PSTRB_EN to add the PSTRB port and
// byte-lane write masking; otherwise every write updates the full word.
// Ports:
//   PCLK, RESET          clock, asynchronous active-high reset
//   PSEL, PENABLE        APB select / access phase
//   PWRITE, PADDR, PWDATA transfer attributes, captured in the setup phase
//   PSTRB                byte strobes (APB_SLAVE_PSTRB_EN only)
//   PRDATA, PREADY, PSLVERR  registered completion response
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                PCLK,
  input  logic                RESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
`ifdef APB_SLAVE_PSTRB_EN
  logic [STRB_W-1:0]   strb_q, strb_d;
`endif

  logic                start_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic                rd_in_range_c;
  logic                rd_en_c;
  logic                wr_en_c;
  logic [STRB_W-1:0]   be_c;

  // Next state, capture and response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
`ifdef APB_SLAVE_PSTRB_EN
    strb_d    = strb_q;
`endif
    pready_d  = 1'b0;
    pslverr_d = APB_OKAY;
    start_c   = 1'b0;
    rd_addr_c = addr_q;

    unique case (state_q)
      ST_IDLE: start_c = PSEL & ~PENABLE;
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          // Last wait cycle: raise PREADY for the following cycle.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d    = '0;
            state_d  = ST_DONE;
            pready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        start_c = PSEL & ~PENABLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_c) begin
      addr_d    = PADDR;
      write_d   = PWRITE;
      wdata_d   = PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
      strb_d    = PSTRB;
`endif
      cnt_d     = WAIT_INIT;
      rd_addr_c = PADDR;
      if (WAIT_STATES == 0) begin
        state_d  = ST_DONE;
        pready_d = 1'b1;
      end else begin
        state_d  = ST_WAIT;
      end
    end

    rd_in_range_c = addr_in_range(32'(rd_addr_c), DEPTH);
    if (pready_d) pslverr_d = rd_in_range_c ? APB_OKAY : APB_ERR;
  end

  // Read is issued on the edge that raises PREADY; write commits on the edge ending it.
  assign rd_en_c = pready_d & ~write_d & rd_in_range_c;
  assign wr_en_c = (state_q == ST_DONE) & write_q & addr_in_range(32'(addr_q), DEPTH);

`ifdef APB_SLAVE_PSTRB_EN
  assign be_c = strb_q;
`else
  assign be_c = '1;
`endif

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLAVE_PSTRB_EN
      strb_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
`ifdef APB_SLAVE_PSTRB_EN
      strb_q    <= strb_d;
`endif
    end
  end

  apb_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (PCLK),
    .rst   (RESET),
    .we    (wr_en_c),
    .waddr (IDX_W'(addr_q)),
    .wdata (wdata_q),
    .be    (be_c),
    .re    (rd_en_c),
    .raddr (IDX_W'(rd_addr_c)),
    .rdata (PRDATA)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule
